// File: rtl/uart_tx_feeder_if.sv
// Byte-write, transmitter-handoff and status signals of uart_tx_feeder.
// Defining UART_TX_FEEDER_OVF_CNT_EN adds the o_ovf_cnt dropped-write count.
interface uart_tx_feeder_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       i_wr_data;
    logic             i_wr_en;
    logic             o_full;
    logic             o_empty;
    logic [FIFO_AW:0] o_level;
    logic [7:0]       o_tx_byte;
    logic             o_activate;
    logic             i_uart_done;
    logic             o_busy;
`ifdef UART_TX_FEEDER_OVF_CNT_EN
    logic [7:0]       o_ovf_cnt;

    // master: the writer/transmitter environment; slave: the feeder itself
    modport master (
        output i_wr_data, i_wr_en, i_uart_done,
        input  o_full, o_empty, o_level, o_tx_byte, o_activate, o_busy, o_ovf_cnt
    );
    modport slave (
        input  i_wr_data, i_wr_en, i_uart_done,
        output o_full, o_empty, o_level, o_tx_byte, o_activate, o_busy, o_ovf_cnt
    );
`else
    modport master (
        output i_wr_data, i_wr_en, i_uart_done,
        input  o_full, o_empty, o_level, o_tx_byte, o_activate, o_busy
    );
    modport slave (
        input  i_wr_data, i_wr_en, i_uart_done,
        output o_full, o_empty, o_level, o_tx_byte, o_activate, o_busy
    );
`endif
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a toggle-activated UART transmitter, one byte per done pulse.
// Optional dropped-write counter enabled by defining UART_TX_FEEDER_OVF_CNT_EN.
module uart_tx_feeder #(
    parameter int FIFO_AW = 4
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    uart_tx_feeder_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [7:0]         tx_byte_reg;
    logic               activate_reg;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_reg == DEPTH_L);
    assign empty = (count_reg == '0);
    // A write while full is dropped even if the head is popped on the same edge
    assign push  = bus.i_wr_en && !full;
    assign pop   = (state_reg == ST_IDLE) && !empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (!empty) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.i_uart_done) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Storage array carries no reset so it maps onto block RAM
    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            tx_byte_reg  <= 8'h00;
            activate_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                tx_byte_reg <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // Byte was registered on the previous edge, so it is stable before the toggle
            if (state_reg == ST_LOAD) activate_reg <= ~activate_reg;
        end
    end

    assign bus.o_full     = full;
    assign bus.o_empty    = empty;
    assign bus.o_level    = count_reg;
    assign bus.o_tx_byte  = tx_byte_reg;
    assign bus.o_activate = activate_reg;
    assign bus.o_busy     = (state_reg != ST_IDLE);

`ifdef UART_TX_FEEDER_OVF_CNT_EN
    logic [7:0] ovf_cnt_reg;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            ovf_cnt_reg <= 8'h00;
        end else if (bus.i_wr_en && full && (ovf_cnt_reg != 8'hFF)) begin
            ovf_cnt_reg <= ovf_cnt_reg + 8'h01;
        end
    end

    assign bus.o_ovf_cnt = ovf_cnt_reg;
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random traffic
// checked each cycle against a queue-based model of the feeder's byte flow.
module tb_uart_tx_feeder;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic sys_rst;

    uart_tx_feeder_if #(.FIFO_AW(AW)) bus ();

    uart_tx_feeder #(.FIFO_AW(AW)) dut (
        .i_sys_clk (clk),
        .i_sys_rst (sys_rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: queued bytes, byte handed to the transmitter, pending toggle
    logic [7:0] mq[$];
    logic [7:0] m_tx;
    bit         m_act;
    bit         m_handed;
    bit         m_pending;
    int         m_ovf;
    int         m_wait;

    // Toggles observed on the DUT (byte shown and new activate level)
    logic [7:0] tog_bytes[$];
    bit         tog_vals[$];
    bit         prev_act;
    int         max_lvl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit w, input logic [7:0] d, input bit dn, input bit r);
        int  lvl;
        bit  acc;
        if (r) begin
            mq.delete();
            m_tx = 8'h00; m_act = 1'b0; m_handed = 1'b0; m_pending = 1'b0; m_ovf = 0;
        end else begin
            lvl = mq.size();
            acc = w && (lvl < DEPTH);
            if (w && !acc && m_ovf < 255) m_ovf++;
            if (m_pending) begin
                m_act = ~m_act;
                m_pending = 1'b0;
            end else if (m_handed) begin
                if (dn) m_handed = 1'b0;
            end else if (lvl > 0) begin
                m_tx = mq.pop_front();
                m_handed = 1'b1;
                m_pending = 1'b1;
            end
            if (acc) mq.push_back(d);
        end
        if (m_handed && !m_pending) m_wait++;
        else m_wait = 0;
    endtask

    task automatic compare_all();
        chk("tx_byte", 32'(bus.o_tx_byte), 32'(m_tx));
        chk("activate", 32'(bus.o_activate), 32'(m_act));
        chk("busy", 32'(bus.o_busy), 32'(m_handed));
        chk("level", 32'(bus.o_level), 32'(mq.size()));
        chk("full", 32'(bus.o_full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(bus.o_empty), 32'(mq.size() == 0));
`ifdef UART_TX_FEEDER_OVF_CNT_EN
        chk("ovf_cnt", 32'(bus.o_ovf_cnt), 32'(m_ovf));
`endif
    endtask

    task automatic cycle(input bit w, input logic [7:0] d, input bit dn, input bit r);
        bus.i_wr_en = w;
        bus.i_wr_data = d;
        bus.i_uart_done = dn;
        sys_rst = r;
        @(posedge clk);
        model_edge(w, d, dn, r);
        #1;
        if (!r && bus.o_activate !== prev_act) begin
            tog_bytes.push_back(bus.o_tx_byte);
            tog_vals.push_back(bus.o_activate);
        end
        prev_act = bus.o_activate;
        if (int'(bus.o_level) > max_lvl) max_lvl = int'(bus.o_level);
        compare_all();
        $display("cyc t=%0t wr=%0b d=%02h done=%0b rst=%0b | tx=%02h act=%0b busy=%0b lvl=%0d",
                 $time, w, d, dn, r, bus.o_tx_byte, bus.o_activate, bus.o_busy, bus.o_level);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        tog_bytes.delete();
        tog_vals.delete();
        max_lvl = 0;
    endtask

    function automatic bit auto_done(input int delay);
        return m_handed && !m_pending && (m_wait >= delay);
    endfunction

    initial begin
        int nxt;
        bit w;
        bit dn;
        int tgt;

        bus.i_wr_en = 1'b0; bus.i_wr_data = 8'h00; bus.i_uart_done = 1'b0;
        sys_rst = 1'b1;
        prev_act = 1'b0;
        mq.delete();
        m_tx = 8'h00; m_act = 1'b0; m_handed = 1'b0; m_pending = 1'b0; m_ovf = 0; m_wait = 0;

        // Reset state
        do_reset();
        chk("rst_tx", 32'(bus.o_tx_byte), 32'h00);
        chk("rst_act", 32'(bus.o_activate), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_empty", 32'(bus.o_empty), 32'h1);
        chk("rst_level", 32'(bus.o_level), 32'h0);

        // Single byte latency: write at E0, byte at E1, toggle at E2
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("e0_level", 32'(bus.o_level), 32'h1);
        chk("e0_busy", 32'(bus.o_busy), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("e1_tx", 32'(bus.o_tx_byte), 32'hA5);
        chk("e1_act", 32'(bus.o_activate), 32'h0);
        chk("e1_busy", 32'(bus.o_busy), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("e2_act", 32'(bus.o_activate), 32'h1);
        chk("e2_busy", 32'(bus.o_busy), 32'h1);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("done_busy", 32'(bus.o_busy), 32'h0);

        // Three back-to-back bytes, done 10 cycles after each toggle
        do_reset();
        prev_act = 1'b0;
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        repeat (60) cycle(1'b0, 8'h00, auto_done(10), 1'b0);
        chk("seq3_count", 32'(tog_bytes.size()), 32'd3);
        for (int i = 0; i < 3 && i < tog_bytes.size(); i++) begin
            chk("seq3_byte", 32'(tog_bytes[i]), 32'(i + 1));
            chk("seq3_actval", 32'(tog_vals[i]), 32'((i + 1) % 2));
        end

        // Fill with no done pulses: 16 queued + 1 in flight, then drops
        do_reset();
        prev_act = 1'b0;
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("fill_full", 32'(bus.o_full), 32'h1);
        chk("fill_level", 32'(bus.o_level), 32'd16);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("drop_level", 32'(bus.o_level), 32'd16);
`ifdef UART_TX_FEEDER_OVF_CNT_EN
        chk("drop_ovf", 32'(bus.o_ovf_cnt), 32'd3);
`endif
        // Drop while full even when a pop happens on the same edge
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0);

        // Pointer wrap: 40 bytes streamed, a new write on each pop
        do_reset();
        prev_act = 1'b0;
        nxt = 0;
        for (int c = 0; c < 1500 && tog_bytes.size() < 40; c++) begin
            w = (nxt < 40) && (nxt < 16 || (!m_handed && mq.size() > 0));
            cycle(w, 8'(nxt), auto_done(2), 1'b0);
            if (w) nxt++;
        end
        chk("wrap_count", 32'(tog_bytes.size()), 32'd40);
        for (int i = 0; i < tog_bytes.size(); i++) chk("wrap_byte", 32'(tog_bytes[i]), 32'(i));
        chk("wrap_maxlvl_le16", 32'(max_lvl <= 16), 32'h1);

        // Done pulses while idle are ignored
        repeat (4) cycle(1'b0, 8'h00, auto_done(1), 1'b0);
        tgt = tog_bytes.size();
        repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("idle_done_tog", 32'(tog_bytes.size()), 32'(tgt));
        chk("idle_done_busy", 32'(bus.o_busy), 32'h0);

        // Reset in WAIT_DONE with 5 bytes queued
        do_reset();
        prev_act = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(bus.o_level), 32'd5);
        chk("pre_rst_act", 32'(bus.o_activate), 32'h1);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        chk("mid_rst_level", 32'(bus.o_level), 32'd0);
        chk("mid_rst_act", 32'(bus.o_activate), 32'h0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'h0);
        tog_bytes.delete();
        repeat (20) cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
        chk("post_rst_tog", 32'(tog_bytes.size()), 32'd0);

        // Random traffic including stray done pulses and rare resets
        do_reset();
        prev_act = 1'b0;
        tgt = 3;
        for (int c = 0; c < 3000; c++) begin
            dn = auto_done(tgt) || ($urandom_range(0, 15) == 0);
            if (auto_done(tgt)) tgt = $urandom_range(1, 12);
            cycle(($urandom_range(0, 2) == 0), 8'($urandom), dn, ($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
